sd_dac_multi: RTL and testbench
===============================

# sd_dac_multi

Multi-channel sigma-delta DAC modulator, the parametrised successor to the single-channel first-order DAC. It accepts signed PCM frames (one sample per channel) through a valid/ready handshake and double-buffers them. It runs a first- or second-order modulator per channel at a programmable modulator rate and drives one 1-bit output pin per channel. It sits between the audio/sample generator and the output pins, with an external RC filter.

## Interface
- BITS, 16, sample width per channel, signed two's complement; legal range 4..24
- CHANNELS, 2, number of independent channels; legal range 1..8
- ORDER, 2, modulator order; 1 or 2, other values illegal
- INV, 1'b1, output polarity; 1 inverts every modulator bit at the pin
- DIV, 1, modulator tick period in clk cycles; legal range 1..65536
- clk  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-low reset
- in_data  input  CHANNELS*BITS  frame; channel c at in_data[c*BITS +: BITS]
- in_valid  input  1  frame offered
- in_ready  output  1  pending buffer empty, frame will be accepted
- mute  input  1  level; while high every channel is modulated with x = 0
- tick  output  1  one-cycle pulse on each modulator step
- underrun  output  1  sticky; set when a tick finds the pending buffer empty
- out  output  CHANNELS  modulated bitstream, registered

## Operation
- Prescaler: counter 0..DIV-1, increments every cycle and wraps to 0. tick = (count == DIV-1). With DIV=1, tick is constantly high.
- Buffering: pending register (frame + full flag) and active register (frame).
- in_ready = ~pending_full. A transfer happens on in_valid & in_ready; it loads pending and sets pending_full.
- On tick with pending_full: active <= pending and pending_full cleared. in_ready is low in that cycle, so a same-cycle accept cannot occur.
- On tick with pending empty: active is held (last frame repeats) and underrun <= 1. underrun clears only on reset.
- Modulator step, per channel, on tick only. x = mute ? 0 : active[c], using active as held before this tick's load.
- ORDER 1:
  - u = {~x[MSB], x[MSB-1:0]}; acc is BITS+1 bits.
  - acc <= acc[BITS-1:0] + u; modulator bit b = acc[BITS] of the updated value.
- ORDER 2:
  - FS = 2^(BITS-1). x is first clamped to [-(7/8)FS, +(7/8)FS].
  - y = b ? +FS : -FS, using the current b.
  - i1' = sat(i1 + x - y), with i1 signed BITS+2 bits.
  - i2' = sat(i2 + i1' - y), with i2 signed BITS+4 bits.
  - b' = (i2' >= 0).
  - sat clamps to the register's signed min/max, with no wrap.
- Pin: out[c] <= b[c] ^ INV, registered every clk cycle.
- Channels are fully independent. No arithmetic state is shared.

## Timing
- While reset is low, each clk edge sets:
  - prescaler, i1, i2, acc, b, active, pending and underrun to 0;
  - pending_full to 0;
  - out to all-zeros, regardless of INV.
- tick and in_ready are combinational, so during reset tick = (DIV==1) and in_ready = 1. Transfers are ignored while reset is low.
- First tick occurs DIV-1 cycles after the first cycle with reset high.
- A frame accepted in cycle t enters active at the first tick strictly after t. It drives the modulator from the next tick after that.
- b updates on the tick edge; out follows one clk later.
- A reset deassertion in the middle of a frame, or reset asserted during a transfer, drops the frame. No partial state survives.
- Sustained throughput: one frame per DIV cycles. Producer stall is allowed; in_valid may drop without a transfer.
- mute takes effect on the next tick. The integrators are not cleared.

## Test plan
- Reset: hold reset low 5 cycles, INV=1 -> out=0, in_ready=1, underrun=0. First tick occurs DIV-1 cycles after release (DIV=4: 3 cycles).
- ORDER=1, INV=0, DIV=1, BITS=16, one channel:
  - frame 0x4000 -> exactly 48 ones in 64 consecutive ticks, pattern period 4;
  - frame 0x0000 -> exactly 32 ones, alternating.
- ORDER=2, INV=0, frame 0:
  - 1024 ticks -> ones count 510..514;
  - frame +0x7000 (clamped to 0x7000) -> ones count 952..968 per 1024, no integrator overflow.
- Handshake, DIV=4: in_valid held high with frames A,B,C -> A accepted immediately; B accepted the cycle after the next tick. No frame lost or duplicated; in_ready never high while pending_full.
- Underrun: no new frames after A -> underrun rises at the second tick after A's load, and A keeps modulating. Reset clears underrun.
- Multi-channel: CHANNELS=4, ORDER=1, frames 0x8000/0x0000/0x4000/0x7FFF -> ones-density per 64 ticks of 0/32/48/63 respectively. mute high -> all channels settle to 32/64 within 64 ticks.

Source files
------------

// File: rtl/sd_dac_multi.sv
`default_nettype none
// ============================================================================
// Module  : sd_dac_multi
// Brief   : Multi-channel 1st/2nd-order sigma-delta DAC modulator with a
//           double-buffered valid/ready frame input and programmable tick rate.
// Revision: 1.0
// ============================================================================
module sd_dac_multi #(
   parameter int   BITS     = 16,
   parameter int   CHANNELS = 2,
   parameter int   ORDER    = 2,
   parameter logic INV      = 1'b1,
   parameter int   DIV      = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [CHANNELS*BITS-1:0] in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     mute,
   output logic                     tick,
   output logic                     underrun,
   output logic [CHANNELS-1:0]      out
);

   localparam int               CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [CHANNELS*BITS-1:0] pend_q, act_q;
   logic                     pend_full_q;
   logic                     underrun_q;
   logic [CHANNELS-1:0]      b_vec;
   logic [CHANNELS-1:0]      out_q;

   always_comb begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
   end

   assign tick     = (cnt_q == CNT_MAX);
   assign in_ready = ~pend_full_q;
   assign underrun = underrun_q;
   assign out      = out_q;

   // An accept needs pending empty, so it never collides with the tick-side load.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q       <= '0;
         pend_q      <= '0;
         pend_full_q <= 1'b0;
         act_q       <= '0;
         underrun_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         if (tick) begin
            if (pend_full_q) begin
               act_q       <= pend_q;
               pend_full_q <= 1'b0;
            end else begin
               underrun_q  <= 1'b1;
            end
         end
         if (in_valid && in_ready) begin
            pend_q      <= in_data;
            pend_full_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         out_q <= '0;
      end else begin
         out_q <= b_vec ^ {CHANNELS{INV}};
      end
   end

   generate
      for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
         logic signed [BITS-1:0] x;
         logic                   b_q, b_d;

         assign x        = mute ? '0 : act_q[c*BITS +: BITS];
         assign b_vec[c] = b_q;

         always_ff @(posedge clk) begin
            if (!reset) begin
               b_q <= 1'b0;
            end else if (tick) begin
               b_q <= b_d;
            end
         end

         if (ORDER == 1) begin : g_o1
            logic [BITS:0] acc_q, acc_d;

            // Offset-binary view of x; the carry out is the modulator bit.
            always_comb begin
               acc_d = {1'b0, acc_q[BITS-1:0]} + {1'b0, ~x[BITS-1], x[BITS-2:0]};
            end
            assign b_d = acc_d[BITS];

            always_ff @(posedge clk) begin
               if (!reset) begin
                  acc_q <= '0;
               end else if (tick) begin
                  acc_q <= acc_d;
               end
            end
         end else begin : g_o2
            localparam int                     W1     = BITS + 2;
            localparam int                     W2     = BITS + 4;
            localparam logic signed [BITS-1:0] X_LIM  = BITS'(7 * 2 ** (BITS - 4));
            localparam logic signed [W1-1:0]   FS_Y   = W1'(2 ** (BITS - 1));
            localparam logic signed [W1:0]     S1_MAX = (W1 + 1)'(2 ** (BITS + 1) - 1);
            localparam logic signed [W1:0]     S1_MIN = (W1 + 1)'(-(2 ** (BITS + 1)));
            localparam logic signed [W2:0]     S2_MAX = (W2 + 1)'(2 ** (BITS + 3) - 1);
            localparam logic signed [W2:0]     S2_MIN = (W2 + 1)'(-(2 ** (BITS + 3)));

            logic signed [BITS-1:0] xc;
            logic signed [W1-1:0]   y, i1_q, i1_d;
            logic signed [W2-1:0]   i2_q, i2_d;
            logic signed [W1:0]     s1;
            logic signed [W2:0]     s2;

            // Sums are one bit wider than the integrators so saturation sees the true value.
            always_comb begin
               xc = x;
               if (x > X_LIM) begin
                  xc = X_LIM;
               end else if (x < -X_LIM) begin
                  xc = -X_LIM;
               end
               y    = b_q ? FS_Y : -FS_Y;
               s1   = (W1 + 1)'(i1_q) + (W1 + 1)'(xc) - (W1 + 1)'(y);
               i1_d = s1[W1-1:0];
               if (s1 > S1_MAX) begin
                  i1_d = S1_MAX[W1-1:0];
               end else if (s1 < S1_MIN) begin
                  i1_d = S1_MIN[W1-1:0];
               end
               s2   = (W2 + 1)'(i2_q) + (W2 + 1)'(i1_d) - (W2 + 1)'(y);
               i2_d = s2[W2-1:0];
               if (s2 > S2_MAX) begin
                  i2_d = S2_MAX[W2-1:0];
               end else if (s2 < S2_MIN) begin
                  i2_d = S2_MIN[W2-1:0];
               end
            end
            assign b_d = ~i2_d[W2-1];

            always_ff @(posedge clk) begin
               if (!reset) begin
                  i1_q <= '0;
                  i2_q <= '0;
               end else if (tick) begin
                  i1_q <= i1_d;
                  i2_q <= i2_d;
               end
            end
         end
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sd_dac_multi.sv
`default_nettype none
// ============================================================================
// Module  : tb_sd_dac_multi
// Brief   : Self-checking bench: density tables for ORDER 1/2 instances and a
//           cycle-level reference model for the buffered DIV=4 instance.
// Revision: 1.0
// ============================================================================
module tb_sd_dac_multi;

   localparam int B    = 16;
   localparam int FS   = 1 << (B - 1);
   localparam int DIV3 = 4;
   localparam int CH3  = 2;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [63:0] d1_data  = '0;
   logic        d1_valid = 1'b0, d1_mute = 1'b0;
   logic        d1_ready, d1_tick, d1_und;
   logic [3:0]  d1_out;

   logic [15:0] d2_data  = '0;
   logic        d2_valid = 1'b0, d2_mute = 1'b0;
   logic        d2_ready, d2_tick, d2_und;
   logic [0:0]  d2_out;

   logic [31:0] d3_data  = '0;
   logic        d3_valid = 1'b0, d3_mute = 1'b0;
   logic        d3_ready, d3_tick, d3_und;
   logic [1:0]  d3_out;

   sd_dac_multi #(.BITS(B), .CHANNELS(4), .ORDER(1), .INV(1'b0), .DIV(1)) u_d1 (
      .clk(clk), .reset(reset), .in_data(d1_data), .in_valid(d1_valid),
      .in_ready(d1_ready), .mute(d1_mute), .tick(d1_tick), .underrun(d1_und),
      .out(d1_out));

   sd_dac_multi #(.BITS(B), .CHANNELS(1), .ORDER(2), .INV(1'b0), .DIV(1)) u_d2 (
      .clk(clk), .reset(reset), .in_data(d2_data), .in_valid(d2_valid),
      .in_ready(d2_ready), .mute(d2_mute), .tick(d2_tick), .underrun(d2_und),
      .out(d2_out));

   sd_dac_multi #(.BITS(B), .CHANNELS(CH3), .ORDER(2), .INV(1'b1), .DIV(DIV3)) u_d3 (
      .clk(clk), .reset(reset), .in_data(d3_data), .in_valid(d3_valid),
      .in_ready(d3_ready), .mute(d3_mute), .tick(d3_tick), .underrun(d3_und),
      .out(d3_out));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic chk_range(input string name, input longint act, input longint lo,
                            input longint hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
      end
   endtask

   // Reference model of the DIV=4, ORDER=2, INV=1 instance
   int          m_cnt  = 0;
   bit          m_pf   = 1'b0;
   bit          m_und  = 1'b0;
   logic [31:0] m_pend = '0;
   logic [31:0] m_act  = '0;
   logic [1:0]  m_out  = '0;
   longint      m_i1 [CH3];
   longint      m_i2 [CH3];
   bit          m_b  [CH3];

   function automatic longint clamp(input longint v, input longint lo, input longint hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   task automatic model_step();
      logic signed [B-1:0] xs;
      longint              x, y;
      bit                  tk, take;
      if (!reset) begin
         m_cnt  = 0;
         m_pf   = 1'b0;
         m_und  = 1'b0;
         m_pend = '0;
         m_act  = '0;
         m_out  = '0;
         for (int c = 0; c < CH3; c++) begin
            m_i1[c] = 0;
            m_i2[c] = 0;
            m_b[c]  = 1'b0;
         end
      end else begin
         tk   = (m_cnt == DIV3 - 1);
         take = d3_valid && !m_pf;
         for (int c = 0; c < CH3; c++) m_out[c] = ~m_b[c];
         if (tk) begin
            for (int c = 0; c < CH3; c++) begin
               xs      = m_act[c*B +: B];
               x       = d3_mute ? 0 : longint'(xs);
               x       = clamp(x, -7 * FS / 8, 7 * FS / 8);
               y       = m_b[c] ? FS : -FS;
               m_i1[c] = clamp(m_i1[c] + x - y, -4 * FS, 4 * FS - 1);
               m_i2[c] = clamp(m_i2[c] + m_i1[c] - y, -16 * FS, 16 * FS - 1);
               m_b[c]  = (m_i2[c] >= 0);
            end
            if (m_pf) begin
               m_act = m_pend;
               m_pf  = 1'b0;
            end else begin
               m_und = 1'b1;
            end
         end
         if (take) begin
            m_pend = d3_data;
            m_pf   = 1'b1;
         end
         m_cnt = (m_cnt + 1) % DIV3;
      end
   endtask

   task automatic clock();
      model_step();
      @(posedge clk);
      @(negedge clk);
      chk("d3_tick", d3_tick, (m_cnt == DIV3 - 1));
      chk("d3_in_ready", d3_ready, !m_pf);
      chk("d3_underrun", d3_und, m_und);
      chk("d3_out", d3_out, m_out);
   endtask

   typedef struct {
      logic [63:0]     frame;
      logic            mute;
      logic [3:0][7:0] lo;
      logic [3:0][7:0] hi;
      int              pat;
   } d1_vec_t;

   typedef struct {
      logic [15:0] frame;
      int          lo;
      int          hi;
   } d2_vec_t;

   d1_vec_t     t1 [4];
   d2_vec_t     t2 [6];
   int          n, idx;
   int          cnt [4];
   int          acc_at [3];
   logic [31:0] fr [3];
   logic [63:0] hist0;
   bit          ok;

   initial begin
      // ch3..ch0 packed MSB-first; 0x7FFF gives 63 or 64 depending on accumulator phase
      t1[0] = '{64'h7FFF_4000_0000_8000, 1'b0, {8'd63, 8'd48, 8'd32, 8'd0},
                {8'd64, 8'd48, 8'd32, 8'd0}, 0};
      t1[1] = '{64'h7FFF_4000_0000_8000, 1'b1, {8'd32, 8'd32, 8'd32, 8'd32},
                {8'd32, 8'd32, 8'd32, 8'd32}, 2};
      t1[2] = '{64'h0001_8001_C000_4000, 1'b0, {8'd32, 8'd0, 8'd16, 8'd48},
                {8'd33, 8'd1, 8'd16, 8'd48}, 4};
      t1[3] = '{64'h0000_0000_0000_0000, 1'b0, {8'd32, 8'd32, 8'd32, 8'd32},
                {8'd32, 8'd32, 8'd32, 8'd32}, 2};
      t2[0] = '{16'h0000, 510, 514};
      t2[1] = '{16'h7000, 952, 968};
      t2[2] = '{16'h7FFF, 952, 968};
      t2[3] = '{16'h9000, 56, 72};
      t2[4] = '{16'h8000, 56, 72};
      t2[5] = '{16'h0000, 510, 514};
      fr[0] = 32'h3000_C000;
      fr[1] = 32'h8000_7FFF;
      fr[2] = 32'h1234_EDCB;

      // Reset: INV=1 must still read back all-zero pins
      reset = 1'b0;
      repeat (5) clock();
      chk("rst_d3_out", d3_out, 0);
      chk("rst_d3_ready", d3_ready, 1);
      chk("rst_d3_underrun", d3_und, 0);
      chk("rst_d3_tick", d3_tick, 0);
      chk("rst_d1_tick", d1_tick, 1);
      chk("rst_d1_out", d1_out, 0);
      chk("rst_d2_out", d2_out, 0);

      // Single frame A then starve: ticks at 3 and 7, underrun visible from 8
      reset    = 1'b1;
      d3_data  = fr[0];
      d3_valid = 1'b1;
      for (int k = 0; k < 12; k++) begin
         chk("d3_tick_phase", d3_tick, (k == 3 || k == 7 || k == 11));
         chk("d3_underrun_seq", d3_und, (k >= 8));
         clock();
         d3_valid = 1'b0;
      end

      reset = 1'b0;
      repeat (2) clock();
      chk("d3_underrun_cleared", d3_und, 0);

      // Back-to-back frames with valid held: accepts at 0, 4, 8
      reset = 1'b1;
      idx   = 0;
      for (int i = 0; i < 3; i++) acc_at[i] = -1;
      for (int k = 0; k < 16; k++) begin
         d3_valid = (idx < 3);
         if (idx < 3) d3_data = fr[idx];
         if (d3_valid && d3_ready) begin
            acc_at[idx] = k;
            idx++;
         end
         clock();
      end
      d3_valid = 1'b0;
      chk("hs_accept_A", acc_at[0], 0);
      chk("hs_accept_B", acc_at[1], 4);
      chk("hs_accept_C", acc_at[2], 8);
      repeat (12) clock();

      // ORDER 1, four channels, 64-tick density windows
      for (int r = 0; r < 4; r++) begin
         d1_data  = t1[r].frame;
         d1_mute  = t1[r].mute;
         d1_valid = 1'b1;
         n = 0;
         while (!d1_ready && n < 8) begin
            clock();
            n++;
         end
         chk("d1_accept", d1_ready, 1);
         clock();
         d1_valid = 1'b0;
         repeat (8) clock();
         for (int c = 0; c < 4; c++) cnt[c] = 0;
         for (int k = 0; k < 64; k++) begin
            hist0[k] = d1_out[0];
            for (int c = 0; c < 4; c++) cnt[c] += int'(d1_out[c]);
            clock();
         end
         for (int c = 0; c < 4; c++)
            chk_range($sformatf("d1_row%0d_ch%0d_ones", r, c), cnt[c], t1[r].lo[c], t1[r].hi[c]);
         if (t1[r].pat == 4) begin
            ok = 1'b1;
            for (int k = 0; k < 60; k++) if (hist0[k] != hist0[k+4]) ok = 1'b0;
            chk($sformatf("d1_row%0d_period4", r), ok, 1);
         end else if (t1[r].pat == 2) begin
            ok = 1'b1;
            for (int k = 0; k < 63; k++) if (hist0[k] == hist0[k+1]) ok = 1'b0;
            chk($sformatf("d1_row%0d_alternate", r), ok, 1);
         end
      end
      d1_mute = 1'b0;

      // ORDER 2, 1024-tick density windows incl. clamp boundaries
      for (int r = 0; r < 6; r++) begin
         d2_data  = t2[r].frame;
         d2_valid = 1'b1;
         n = 0;
         while (!d2_ready && n < 8) begin
            clock();
            n++;
         end
         chk("d2_accept", d2_ready, 1);
         clock();
         d2_valid = 1'b0;
         repeat (128) clock();
         cnt[0] = 0;
         for (int k = 0; k < 1024; k++) begin
            cnt[0] += int'(d2_out[0]);
            clock();
         end
         chk_range($sformatf("d2_row%0d_ones", r), cnt[0], t2[r].lo, t2[r].hi);
      end

      // Randomised traffic, mute and sporadic resets against the model
      for (int k = 0; k < 1500; k++) begin
         reset    = ($urandom_range(0, 149) != 0);
         d3_valid = ($urandom_range(0, 2) != 0);
         d3_data  = ($urandom_range(0, 7) == 0) ? 32'h8000_7FFF : $urandom;
         if (k % 64 == 0) d3_mute = ($urandom_range(0, 3) == 0);
         clock();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
